tlb_mport: RTL and testbench

- Parametrised, multi-port successor to the single-cycle MIPS TLB.
- N_LOOKUP independent lookup channels, each with a registered one-cycle-latency result and built-in exception classification (refill, invalid, modified).
- Handshaked CP0 op unit for TLBP, TLBR, TLBWI and TLBWR.
- Owns the Random register, including Wired handling.
- Sits in mycpu/impl/mmu between the fetch/memory stages and CP0.

---
 rtl/translation_pkg.sv | 65 ++++++
 rtl/tlb_match.sv | 30 +++
 rtl/tlb_mport.sv | 243 ++++++++++++++++++++++++
 tb/tb_tlb_mport.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/translation_pkg.sv
// Shared types for the multi-port TLB: CP0 register images, the stored
// entry format, op codes and the per-channel lookup response.
package translation_pkg;

    localparam int VPN2_W     = 19;
    // Entries are stored at the widest PFN/ASID the 32-bit CP0 images allow;
    // narrower configurations mask the upper bits on write.
    localparam int MAX_PFN_W  = 20;
    localparam int MAX_ASID_W = 8;

    typedef enum logic [1:0] {
        OP_TLBP  = 2'd0,
        OP_TLBR  = 2'd1,
        OP_TLBWI = 2'd2,
        OP_TLBWR = 2'd3
    } tlb_op_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } tlb_op_state_e;

    typedef struct packed {
        logic [VPN2_W-1:0]     vpn2;
        logic [4:0]            zero;
        logic [MAX_ASID_W-1:0] asid;
    } cp0_entryhi_t;

    typedef struct packed {
        logic [1:0]  fill;
        logic [23:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
        logic        g;
    } cp0_entrylo_t;

    typedef struct packed {
        logic        p;
        logic [30:0] index;
    } cp0_index_t;

    typedef struct packed {
        logic [VPN2_W-1:0]     vpn2;
        logic [MAX_ASID_W-1:0] asid;
        logic                  g;
        logic [MAX_PFN_W-1:0]  pfn0;
        logic [2:0]            c0;
        logic                  d0;
        logic                  v0;
        logic [MAX_PFN_W-1:0]  pfn1;
        logic [2:0]            c1;
        logic                  d1;
        logic                  v1;
    } tlb_entry_t;

    typedef struct packed {
        logic [31:0] paddr;
        logic [2:0]  cache;
        logic        refill;
        logic        invalid;
        logic        modified;
    } tlb_lk_resp_t;

endpackage

// File: rtl/tlb_match.sv
// Combinational priority matcher: finds the lowest-indexed entry whose VPN2
// matches and whose ASID matches or is global. Index is 0 on a miss.
module tlb_match
    import translation_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic [ENTRIES-1:0][VPN2_W-1:0]     i_vpn2_tab,
    input  logic [ENTRIES-1:0][MAX_ASID_W-1:0] i_asid_tab,
    input  logic [ENTRIES-1:0]                 i_g_tab,
    input  logic [VPN2_W-1:0]                  i_vpn2,
    input  logic [MAX_ASID_W-1:0]              i_asid,
    output logic                               o_hit,
    output logic [IDX_W-1:0]                   o_idx
);

    // Scan downward so the lowest matching index is the last one assigned.
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int i = ENTRIES-1; i >= 0; i--) begin
            if (i_vpn2_tab[i] == i_vpn2 && (i_asid_tab[i] == i_asid || i_g_tab[i])) begin
                o_hit = 1'b1;
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/tlb_mport.sv
// Multi-port MIPS TLB: N_LOOKUP registered lookup channels with exception
// classification, a two-state CP0 op unit (TLBP/TLBR/TLBWI/TLBWR) and the
// Random register with Wired handling.
module tlb_mport
    import translation_pkg::*;
#(
    parameter int TLB_ENTRIES = 16,
    parameter int N_LOOKUP    = 2,
    parameter int ASID_W      = 8,
    parameter int PFN_W       = 20,
    parameter int IDX_W       = $clog2(TLB_ENTRIES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ASID_W-1:0]     asid,
    input  logic [N_LOOKUP-1:0]   lk_req,
    input  logic [N_LOOKUP*32-1:0] lk_vaddr,
    input  logic [N_LOOKUP-1:0]   lk_is_store,
    output logic [N_LOOKUP-1:0]   lk_resp_valid,
    output logic [N_LOOKUP*32-1:0] lk_paddr,
    output logic [N_LOOKUP*3-1:0] lk_cache,
    output logic [N_LOOKUP-1:0]   lk_refill,
    output logic [N_LOOKUP-1:0]   lk_invalid,
    output logic [N_LOOKUP-1:0]   lk_modified,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [1:0]            op_code,
    input  logic [IDX_W-1:0]      op_index,
    input  logic [31:0]           op_entryhi,
    input  logic [31:0]           op_entrylo0,
    input  logic [31:0]           op_entrylo1,
    output logic                  op_done,
    output logic [31:0]           op_rd_entryhi,
    output logic [31:0]           op_rd_entrylo0,
    output logic [31:0]           op_rd_entrylo1,
    output logic [31:0]           op_probe_index,
    input  logic [IDX_W-1:0]      wired,
    input  logic                  wired_we,
    output logic [IDX_W-1:0]      random
);

    localparam logic [IDX_W-1:0]      LAST_IDX  = IDX_W'(TLB_ENTRIES-1);
    localparam logic [MAX_PFN_W-1:0]  PFN_MASK  = MAX_PFN_W'((64'd1 << PFN_W) - 64'd1);
    localparam logic [MAX_ASID_W-1:0] ASID_MASK = MAX_ASID_W'((64'd1 << ASID_W) - 64'd1);

    tlb_entry_t r_tab [TLB_ENTRIES];

    logic [TLB_ENTRIES-1:0][VPN2_W-1:0]     w_vpn2_tab;
    logic [TLB_ENTRIES-1:0][MAX_ASID_W-1:0] w_asid_tab;
    logic [TLB_ENTRIES-1:0]                 w_g_tab;
    logic [MAX_ASID_W-1:0]                  w_asid;

    cp0_entryhi_t w_hi;
    cp0_entrylo_t w_lo0, w_lo1;
    tlb_entry_t   w_new, w_rd_e;
    tlb_op_e      w_op;

    tlb_op_state_e r_state, w_state_nxt;
    logic          w_accept;

    logic [IDX_W-1:0] r_random, w_random_nxt;
    logic             w_p_hit;
    logic [IDX_W-1:0] w_p_idx;

    logic w_unused;

    assign w_asid = MAX_ASID_W'(asid) & ASID_MASK;
    assign w_hi   = cp0_entryhi_t'(op_entryhi);
    assign w_lo0  = cp0_entrylo_t'(op_entrylo0);
    assign w_lo1  = cp0_entrylo_t'(op_entrylo1);
    assign w_op   = tlb_op_e'(op_code);
    assign w_rd_e = r_tab[op_index];
    assign random = r_random;

    assign w_unused = ^{w_hi.zero, w_lo0.fill, w_lo0.pfn[23:20], w_lo1.fill, w_lo1.pfn[23:20]};

    // Flatten the match-relevant fields for the priority matchers.
    always_comb begin
        for (int i = 0; i < TLB_ENTRIES; i++) begin
            w_vpn2_tab[i] = r_tab[i].vpn2;
            w_asid_tab[i] = r_tab[i].asid;
            w_g_tab[i]    = r_tab[i].g;
        end
    end

    // Per-channel lookup: match, pick even/odd page, classify, register.
    for (genvar c = 0; c < N_LOOKUP; c++) begin : g_lk
        logic [31:0]          w_va;
        logic                 w_hit;
        logic [IDX_W-1:0]     w_idx;
        logic [MAX_PFN_W-1:0] w_pfn;
        logic [2:0]           w_c;
        logic                 w_d, w_v;
        tlb_lk_resp_t         w_resp, r_resp;
        logic                 r_vld;

        assign w_va = lk_vaddr[c*32 +: 32];

        tlb_match #(.ENTRIES(TLB_ENTRIES), .IDX_W(IDX_W)) u_match (
            .i_vpn2_tab (w_vpn2_tab),
            .i_asid_tab (w_asid_tab),
            .i_g_tab    (w_g_tab),
            .i_vpn2     (w_va[31:13]),
            .i_asid     (w_asid),
            .o_hit      (w_hit),
            .o_idx      (w_idx)
        );

        // Classify against the table as it stands this cycle (no write bypass).
        always_comb begin
            w_pfn  = w_va[12] ? r_tab[w_idx].pfn1 : r_tab[w_idx].pfn0;
            w_c    = w_va[12] ? r_tab[w_idx].c1   : r_tab[w_idx].c0;
            w_d    = w_va[12] ? r_tab[w_idx].d1   : r_tab[w_idx].d0;
            w_v    = w_va[12] ? r_tab[w_idx].v1   : r_tab[w_idx].v0;
            w_resp = '0;
            if (lk_req[c]) begin
                if (w_hit) begin
                    w_resp.paddr    = {w_pfn, w_va[11:0]};
                    w_resp.cache    = w_c;
                    w_resp.invalid  = !w_v;
                    w_resp.modified = w_v && !w_d && lk_is_store[c];
                end else begin
                    w_resp.refill   = 1'b1;
                end
            end
        end

        // One-cycle registered result.
        always_ff @(posedge clk) begin
            if (reset) begin
                r_resp <= '0;
                r_vld  <= 1'b0;
            end else begin
                r_resp <= w_resp;
                r_vld  <= lk_req[c];
            end
        end

        assign lk_resp_valid[c]     = r_vld;
        assign lk_paddr[c*32 +: 32] = r_resp.paddr;
        assign lk_cache[c*3 +: 3]   = r_resp.cache;
        assign lk_refill[c]         = r_resp.refill;
        assign lk_invalid[c]        = r_resp.invalid;
        assign lk_modified[c]       = r_resp.modified;
    end

    // TLBP matcher shares the lookup priority rule.
    tlb_match #(.ENTRIES(TLB_ENTRIES), .IDX_W(IDX_W)) u_probe (
        .i_vpn2_tab (w_vpn2_tab),
        .i_asid_tab (w_asid_tab),
        .i_g_tab    (w_g_tab),
        .i_vpn2     (w_hi.vpn2),
        .i_asid     (w_asid),
        .o_hit      (w_p_hit),
        .o_idx      (w_p_idx)
    );

    // Entry image built from the CP0 registers for TLBWI/TLBWR.
    always_comb begin
        w_new      = '0;
        w_new.vpn2 = w_hi.vpn2;
        w_new.asid = w_hi.asid & ASID_MASK;
        w_new.g    = w_lo0.g & w_lo1.g;
        w_new.pfn0 = w_lo0.pfn[MAX_PFN_W-1:0] & PFN_MASK;
        w_new.c0   = w_lo0.c;
        w_new.d0   = w_lo0.d;
        w_new.v0   = w_lo0.v;
        w_new.pfn1 = w_lo1.pfn[MAX_PFN_W-1:0] & PFN_MASK;
        w_new.c1   = w_lo1.c;
        w_new.d1   = w_lo1.d;
        w_new.v1   = w_lo1.v;
    end

    // Op FSM state register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Op FSM: accept in IDLE, pulse done in RESP.
    always_comb begin
        w_state_nxt = r_state;
        op_ready    = 1'b0;
        op_done     = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                op_done     = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Table storage; reset wins over a write accepted in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < TLB_ENTRIES; i++) r_tab[i] <= '0;
        end else if (w_accept && w_op == OP_TLBWI) begin
            r_tab[op_index] <= w_new;
        end else if (w_accept && w_op == OP_TLBWR) begin
            r_tab[r_random] <= w_new;
        end
    end

    // TLBR / TLBP results, each held until the next op of its kind.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_rd_entryhi  <= '0;
            op_rd_entrylo0 <= '0;
            op_rd_entrylo1 <= '0;
            op_probe_index <= '0;
        end else if (w_accept && w_op == OP_TLBR) begin
            op_rd_entryhi  <= cp0_entryhi_t'{vpn2: w_rd_e.vpn2, zero: '0, asid: w_rd_e.asid};
            op_rd_entrylo0 <= cp0_entrylo_t'{fill: '0, pfn: 24'(w_rd_e.pfn0), c: w_rd_e.c0,
                                             d: w_rd_e.d0, v: w_rd_e.v0, g: w_rd_e.g};
            op_rd_entrylo1 <= cp0_entrylo_t'{fill: '0, pfn: 24'(w_rd_e.pfn1), c: w_rd_e.c1,
                                             d: w_rd_e.d1, v: w_rd_e.v1, g: w_rd_e.g};
        end else if (w_accept && w_op == OP_TLBP) begin
            op_probe_index <= cp0_index_t'{p: ~w_p_hit, index: 31'(w_p_idx)};
        end
    end

    // Random counts down from the top, wrapping back once it reaches Wired.
    always_comb begin
        if (wired_we || r_random <= wired) w_random_nxt = LAST_IDX;
        else                               w_random_nxt = r_random - IDX_W'(1);
    end

    // Random register.
    always_ff @(posedge clk) begin
        if (reset) r_random <= LAST_IDX;
        else       r_random <= w_random_nxt;
    end

endmodule

// File: tb/tb_tlb_mport.sv
// Directed bench for tlb_mport: lookup vector table plus hand-written
// sequences for op timing, write/lookup ordering, Random and reset.
module tb_tlb_mport;
    localparam int ENT = 16;
    localparam int NL  = 2;
    localparam int IW  = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [7:0]      asid;
    logic [NL-1:0]   lk_req, lk_is_store;
    logic [NL*32-1:0] lk_vaddr;
    logic [NL-1:0]   lk_resp_valid, lk_refill, lk_invalid, lk_modified;
    logic [NL*32-1:0] lk_paddr;
    logic [NL*3-1:0] lk_cache;
    logic            op_valid, op_ready, op_done, wired_we;
    logic [1:0]      op_code;
    logic [IW-1:0]   op_index, wired, random;
    logic [31:0]     op_entryhi, op_entrylo0, op_entrylo1;
    logic [31:0]     op_rd_entryhi, op_rd_entrylo0, op_rd_entrylo1, op_probe_index;

    tlb_mport #(.TLB_ENTRIES(ENT), .N_LOOKUP(NL), .ASID_W(8), .PFN_W(20)) dut (
        .clk(clk), .reset(reset), .asid(asid),
        .lk_req(lk_req), .lk_vaddr(lk_vaddr), .lk_is_store(lk_is_store),
        .lk_resp_valid(lk_resp_valid), .lk_paddr(lk_paddr), .lk_cache(lk_cache),
        .lk_refill(lk_refill), .lk_invalid(lk_invalid), .lk_modified(lk_modified),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code), .op_index(op_index),
        .op_entryhi(op_entryhi), .op_entrylo0(op_entrylo0), .op_entrylo1(op_entrylo1),
        .op_done(op_done), .op_rd_entryhi(op_rd_entryhi), .op_rd_entrylo0(op_rd_entrylo0),
        .op_rd_entrylo1(op_rd_entrylo1), .op_probe_index(op_probe_index),
        .wired(wired), .wired_we(wired_we), .random(random)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    typedef struct {
        logic [7:0]  asid;
        int          ch;
        logic [31:0] va;
        logic        st;
        logic [31:0] paddr;
        logic [2:0]  cache;
        logic        rf, iv, md;
    } vec_t;

    vec_t        vecs[5];
    logic [3:0]  rexp[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic lk_issue(input int ch, input logic [31:0] va, input logic st);
        lk_req      = '0;
        lk_is_store = '0;
        lk_req[ch]      = 1'b1;
        lk_is_store[ch] = st;
        lk_vaddr[ch*32 +: 32] = va;
    endtask

    task automatic lk_chk(input string nm, input int ch, input logic [31:0] pa, input logic [2:0] ca,
                          input logic rf, input logic iv, input logic md);
        chk({nm, ".valid"}, 32'(lk_resp_valid[ch]), 32'd1);
        chk({nm, ".paddr"}, lk_paddr[ch*32 +: 32], pa);
        chk({nm, ".cache"}, 32'(lk_cache[ch*3 +: 3]), 32'(ca));
        chk({nm, ".flags"}, 32'({lk_refill[ch], lk_invalid[ch], lk_modified[ch]}), 32'({rf, iv, md}));
    endtask

    // Drive an op at the current negedge; check the done pulse and ready timing.
    task automatic do_op(input string nm, input logic [1:0] code, input logic [3:0] idx,
                         input logic [31:0] hi, input logic [31:0] lo0, input logic [31:0] lo1);
        op_valid = 1'b1; op_code = code; op_index = idx;
        op_entryhi = hi; op_entrylo0 = lo0; op_entrylo1 = lo1;
        @(negedge clk);
        op_valid = 1'b0;
        chk({nm, ".done_pulse"}, 32'(op_done), 32'd1);
        chk({nm, ".ready_low"},  32'(op_ready), 32'd0);
        @(negedge clk);
        chk({nm, ".done_end"},   32'(op_done), 32'd0);
        chk({nm, ".ready_back"}, 32'(op_ready), 32'd1);
    endtask

    initial begin
        vecs[0] = '{8'd5, 0, 32'h00400ABC, 1'b0, 32'h12345ABC, 3'd3, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'd5, 1, 32'h00400ABC, 1'b1, 32'h12345ABC, 3'd3, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{8'd5, 0, 32'h00401000, 1'b0, 32'h54321000, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{8'd6, 0, 32'h00400ABC, 1'b0, 32'h00000000, 3'd0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'd5, 1, 32'h00401FFF, 1'b1, 32'h54321FFF, 3'd0, 1'b0, 1'b1, 1'b0};
        rexp = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd15, 4'd14, 4'd13, 4'd12};

        reset = 1'b1; asid = 8'd0; lk_req = '0; lk_is_store = '0; lk_vaddr = '0;
        op_valid = 1'b0; op_code = 2'd0; op_index = '0;
        op_entryhi = '0; op_entrylo0 = '0; op_entrylo1 = '0;
        wired = '0; wired_we = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst.random", 32'(random), 32'd15);
        chk("rst.ready", 32'(op_ready), 32'd1);
        chk("rst.done", 32'(op_done), 32'd0);
        chk("rst.resp_valid", 32'(lk_resp_valid), 32'd0);
        chk("rst.probe", op_probe_index, 32'd0);
        lk_req = 2'b11; lk_vaddr = {32'h00400000, 32'h00400000};
        @(negedge clk);
        lk_chk("rst.lk0", 0, 32'd0, 3'd0, 1'b1, 1'b0, 1'b0);
        lk_chk("rst.lk1", 1, 32'd0, 3'd0, 1'b1, 1'b0, 1'b0);
        lk_req = '0;

        // TLBWI idx 3, then the lookup vector table
        do_op("wi3", 2'd2, 4'd3, 32'h00400005, 32'h0048D15A, 32'h0150C840);
        for (int k = 0; k < 5; k++) begin
            asid = vecs[k].asid;
            lk_issue(vecs[k].ch, vecs[k].va, vecs[k].st);
            @(negedge clk);
            lk_chk($sformatf("vec%0d", k), vecs[k].ch, vecs[k].paddr, vecs[k].cache,
                   vecs[k].rf, vecs[k].iv, vecs[k].md);
        end
        asid = 8'd5;
        lk_req = '0;
        @(negedge clk);
        chk("idle.resp_valid", 32'(lk_resp_valid), 32'd0);
        chk("idle.flags", 32'({lk_refill, lk_invalid, lk_modified}), 32'd0);

        // Lookup in the write-accept cycle sees the old entry; next cycle hits
        op_valid = 1'b1; op_code = 2'd2; op_index = 4'd4;
        op_entryhi = 32'h00800005; op_entrylo0 = 32'h002AAA96; op_entrylo1 = 32'h002AAA96;
        lk_issue(0, 32'h00800010, 1'b0);
        @(negedge clk);
        op_valid = 1'b0;
        lk_chk("ord.same", 0, 32'd0, 3'd0, 1'b1, 1'b0, 1'b0);
        chk("ord.done", 32'(op_done), 32'd1);
        @(negedge clk);
        lk_chk("ord.next", 0, 32'h0AAAA010, 3'd2, 1'b0, 1'b0, 1'b0);
        chk("ord.done_end", 32'(op_done), 32'd0);
        lk_req = '0;

        // TLBP hit and miss
        do_op("tlbp_hit", 2'd0, 4'd0, 32'h00400005, 32'd0, 32'd0);
        chk("tlbp_hit.index", op_probe_index, 32'h00000003);
        do_op("tlbp_miss", 2'd0, 4'd0, 32'h12340005, 32'd0, 32'd0);
        chk("tlbp_miss.index", op_probe_index, 32'h80000000);

        // Random with Wired = 10, then TLBWR at random = 12
        wired = 4'd10; wired_we = 1'b1;
        @(negedge clk);
        wired_we = 1'b0;
        for (int k = 0; k < 10; k++) begin
            chk($sformatf("random[%0d]", k), 32'(random), 32'(rexp[k]));
            if (k < 9) @(negedge clk);
        end
        do_op("tlbwr", 2'd3, 4'd0, 32'h00C01F05, 32'hC002AF17, 32'hC0037BDA);
        do_op("tlbr12", 2'd1, 4'd12, 32'd0, 32'd0, 32'd0);
        chk("tlbr12.hi",  op_rd_entryhi,  32'h00C00005);
        chk("tlbr12.lo0", op_rd_entrylo0, 32'h0002AF16);
        chk("tlbr12.lo1", op_rd_entrylo1, 32'h00037BDA);
        chk("tlbr12.probe_held", op_probe_index, 32'h80000000);
        lk_issue(1, 32'h00C00044, 1'b0);
        @(negedge clk);
        lk_chk("wr12.lk", 1, 32'h00ABC044, 3'd2, 1'b0, 1'b0, 1'b0);
        lk_req = '0;

        // Wired at the top pins Random
        wired = 4'd15;
        repeat (2) @(negedge clk);
        chk("pin.random0", 32'(random), 32'd15);
        @(negedge clk);
        chk("pin.random1", 32'(random), 32'd15);
        wired = 4'd0;

        // Duplicate global VPN2 at idx 7 and 2: lowest index wins
        do_op("wi7", 2'd2, 4'd7, 32'h00A00001, 32'h01DDDDCF, 32'h01DDDDCF);
        do_op("wi2", 2'd2, 4'd2, 32'h00A00001, 32'h00888897, 32'h00888897);
        asid = 8'd9;
        lk_issue(0, 32'h00A00123, 1'b1);
        @(negedge clk);
        lk_chk("dup.lk", 0, 32'h22222123, 3'd2, 1'b0, 1'b0, 1'b0);
        lk_req = '0;
        asid = 8'd5;

        // Reset in the op-accept cycle discards the op
        reset = 1'b1; op_valid = 1'b1; op_code = 2'd2; op_index = 4'd5;
        op_entryhi = 32'h01000005; op_entrylo0 = 32'h00000006; op_entrylo1 = 32'h00000006;
        @(negedge clk);
        reset = 1'b0; op_valid = 1'b0;
        chk("rmid.done0", 32'(op_done), 32'd0);
        chk("rmid.ready", 32'(op_ready), 32'd1);
        chk("rmid.random", 32'(random), 32'd15);
        @(negedge clk);
        chk("rmid.done1", 32'(op_done), 32'd0);
        do_op("rmid.tlbr", 2'd1, 4'd5, 32'd0, 32'd0, 32'd0);
        chk("rmid.hi", op_rd_entryhi, 32'd0);
        chk("rmid.lo0", op_rd_entrylo0, 32'd0);
        lk_issue(0, 32'h01000000, 1'b0);
        @(negedge clk);
        lk_chk("rmid.lk", 0, 32'd0, 3'd0, 1'b1, 1'b0, 1'b0);
        lk_req = '0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
